// File: rtl/pipe_pkg.sv
// Shared constants and elaboration helpers for the select/pipeline stage family.
// State codes are the {main_v, skid_v} occupancy pair.
package pipe_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 32'd0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < value) begin
        res = i + 1;
      end
    end
    return res;
  endfunction

  // Select width never drops below one bit so a port always exists.
  function automatic int unsigned sel_width(input int unsigned num_in);
    return (num_in < 32'd2) ? 32'd1 : clog2(num_in);
  endfunction

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b10;
  localparam logic [1:0] ST_FULL  = 2'b11;

endpackage

// File: rtl/pipe_mux_n.sv
// Combinational N:1 source selector; an out-of-range index falls back to source 0
// and the index actually used is reported alongside the data.
module pipe_mux_n
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  output logic [WIDTH-1:0]        sel_data,
  output logic [SEL_W-1:0]        eff_sel
);

  localparam logic [SEL_W:0] NUM_LIMIT = (SEL_W + 1)'(NUM_IN);

  // Range clamp followed by the source pick.
  always_comb begin
    if ({1'b0, in_sel} < NUM_LIMIT) begin
      eff_sel = in_sel;
    end else begin
      eff_sel = {SEL_W{1'b0}};
    end
    sel_data = in_data[int'(eff_sel)*WIDTH +: WIDTH];
  end

endmodule

// File: rtl/pipe_sel_stage.sv
// Registered N:1 select stage with valid/ready handshake, optional 2-entry skid
// buffer (registered in_ready) and synchronous flush.
module pipe_sel_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SKID   = 1,
  localparam int SEL_W = sel_width(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready
);

  logic [WIDTH-1:0] mux_data_s;
  logic [SEL_W-1:0] mux_sel_s;
  logic             main_v_r, skid_v_r, in_ready_r;
  logic [WIDTH-1:0] main_data_r, skid_data_r;
  logic [SEL_W-1:0] main_sel_r, skid_sel_r;
  logic             main_v_c, skid_v_c, main_v_n, skid_v_n;
  logic [WIDTH-1:0] main_data_c, skid_data_c, main_data_n, skid_data_n;
  logic [SEL_W-1:0] main_sel_c, skid_sel_c, main_sel_n, skid_sel_n;
  logic             accept_s, transfer_s, in_ready_s;

  pipe_mux_n #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) u_mux (
    .in_data  (in_data),
    .in_sel   (in_sel),
    .sel_data (mux_data_s),
    .eff_sel  (mux_sel_s)
  );

  // Without a skid entry the ONE+accept+!transfer arm is unreachable, so one FSM serves both.
  assign in_ready_s = (SKID != 0) ? in_ready_r : (~main_v_r | out_ready);
  assign accept_s   = in_valid & in_ready_s;
  assign transfer_s = main_v_r & out_ready;

  // Occupancy transitions and data routing between input, main and skid.
  always_comb begin
    main_v_c    = main_v_r;
    skid_v_c    = skid_v_r;
    main_data_c = main_data_r;
    main_sel_c  = main_sel_r;
    skid_data_c = skid_data_r;
    skid_sel_c  = skid_sel_r;
    case ({main_v_r, skid_v_r})
      ST_EMPTY: begin
        if (accept_s) begin
          main_v_c    = 1'b1;
          main_data_c = mux_data_s;
          main_sel_c  = mux_sel_s;
        end else begin
          main_v_c = 1'b0;
        end
      end
      ST_ONE: begin
        if (accept_s && transfer_s) begin
          main_data_c = mux_data_s;
          main_sel_c  = mux_sel_s;
        end else if (accept_s) begin
          skid_v_c    = 1'b1;
          skid_data_c = mux_data_s;
          skid_sel_c  = mux_sel_s;
        end else if (transfer_s) begin
          main_v_c = 1'b0;
        end else begin
          main_v_c = 1'b1;
        end
      end
      ST_FULL: begin
        if (transfer_s) begin
          skid_v_c    = 1'b0;
          main_data_c = skid_data_r;
          main_sel_c  = skid_sel_r;
        end else begin
          skid_v_c = 1'b1;
        end
      end
      default: begin
        main_v_c = 1'b0;
        skid_v_c = 1'b0;
      end
    endcase
  end

  // Flush kills every entry and drops the same-cycle accept; held data is left as is.
  assign main_v_n    = flush ? 1'b0 : main_v_c;
  assign skid_v_n    = flush ? 1'b0 : skid_v_c;
  assign main_data_n = flush ? main_data_r : main_data_c;
  assign main_sel_n  = flush ? main_sel_r  : main_sel_c;
  assign skid_data_n = flush ? skid_data_r : skid_data_c;
  assign skid_sel_n  = flush ? skid_sel_r  : skid_sel_c;

  // State registers; in_ready_r mirrors the next skid occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_v_r    <= 1'b0;
      skid_v_r    <= 1'b0;
      in_ready_r  <= 1'b1;
      main_data_r <= {WIDTH{1'b0}};
      main_sel_r  <= {SEL_W{1'b0}};
      skid_data_r <= {WIDTH{1'b0}};
      skid_sel_r  <= {SEL_W{1'b0}};
    end else begin
      main_v_r    <= main_v_n;
      skid_v_r    <= skid_v_n;
      in_ready_r  <= ~skid_v_n;
      main_data_r <= main_data_n;
      main_sel_r  <= main_sel_n;
      skid_data_r <= skid_data_n;
      skid_sel_r  <= skid_sel_n;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = main_v_r;
  assign out_data  = main_data_r;
  assign out_sel   = main_sel_r;

endmodule

// File: tb/tb_pipe_sel_stage.sv
// Scoreboard bench for pipe_sel_stage: three instances (4-way skid, 3-way skid, 4-way no-skid).
`timescale 1ns/1ps
module tb_pipe_sel_stage;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // 4-way, WIDTH 32, skid
  logic [127:0] din4 = 128'd0;
  logic [1:0]   sel4 = 2'd0, os4;
  logic         iv4 = 1'b0, fl4 = 1'b0, ordy4 = 1'b0, ir4, ov4;
  logic [31:0]  od4;
  // 3-way, WIDTH 8, skid
  logic [23:0]  din3 = 24'd0;
  logic [1:0]   sel3 = 2'd0, os3;
  logic         iv3 = 1'b0, ordy3 = 1'b0, ir3, ov3;
  logic [7:0]   od3;
  // 4-way, WIDTH 32, no skid
  logic [127:0] din0 = 128'd0;
  logic [1:0]   sel0 = 2'd0, os0;
  logic         iv0 = 1'b0, ordy0 = 1'b0, ir0, ov0;
  logic [31:0]  od0;

  logic [63:0] q4[$], q3[$], q0[$];
  logic [63:0] e4, e3, e0;

  pipe_sel_stage #(.WIDTH(32), .NUM_IN(4), .SKID(1)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_data(din4), .in_sel(sel4), .in_valid(iv4),
    .in_ready(ir4), .flush(fl4), .out_data(od4), .out_sel(os4), .out_valid(ov4),
    .out_ready(ordy4));

  pipe_sel_stage #(.WIDTH(8), .NUM_IN(3), .SKID(1)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_data(din3), .in_sel(sel3), .in_valid(iv3),
    .in_ready(ir3), .flush(1'b0), .out_data(od3), .out_sel(os3), .out_valid(ov3),
    .out_ready(ordy3));

  pipe_sel_stage #(.WIDTH(32), .NUM_IN(4), .SKID(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .in_data(din0), .in_sel(sel0), .in_valid(iv0),
    .in_ready(ir0), .flush(1'b0), .out_data(od0), .out_sel(os0), .out_valid(ov0),
    .out_ready(ordy0));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference select: clamp the index, pack {effective index, data}.
  function automatic logic [63:0] exp_word(input logic [127:0] src, input int sel,
                                           input int num, input int width);
    int eff;
    logic [127:0] sh;
    logic [63:0] mask;
    eff  = (sel < num) ? sel : 0;
    sh   = src >> (eff * width);
    mask = (64'd1 << width) - 64'd1;
    return (64'(eff) << width) | (sh[63:0] & mask);
  endfunction

  // Scoreboards: pop on transfer first, then push what the next edge accepts.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ov4 && ordy4) begin
        if (q4.size() == 0) check("d4_spurious", 64'(ov4), 64'd0);
        else begin e4 = q4.pop_front(); check("d4_out", {30'd0, os4, od4}, e4); end
      end
      if (iv4 && ir4 && !fl4) q4.push_back(exp_word(din4, int'(sel4), 4, 32));
      if (ov3 && ordy3) begin
        if (q3.size() == 0) check("d3_spurious", 64'(ov3), 64'd0);
        else begin e3 = q3.pop_front(); check("d3_out", {54'd0, os3, od3}, e3); end
      end
      if (iv3 && ir3) q3.push_back(exp_word({104'd0, din3}, int'(sel3), 3, 8));
      if (ov0 && ordy0) begin
        if (q0.size() == 0) check("d0_spurious", 64'(ov0), 64'd0);
        else begin e0 = q0.pop_front(); check("d0_out", {30'd0, os0, od0}, e0); end
      end
      if (iv0 && ir0) q0.push_back(exp_word(din0, int'(sel0), 4, 32));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset and basic select
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ov", 64'(ov4), 64'd0);
    check("rst_od", 64'(od4), 64'd0);
    check("rst_os", 64'(os4), 64'd0);
    check("rst_ir", 64'(ir4), 64'd1);
    check("rst_ir0", 64'(ir0), 64'd1);
    #1 reset_n = 1'b1;
    step(); din4 = {32'h44, 32'h33, 32'h22, 32'h11}; sel4 = 2'd2; iv4 = 1'b1; ordy4 = 1'b1;
    @(negedge clk); check("sel_ir", 64'(ir4), 64'd1);
    step(); iv4 = 1'b0;
    @(negedge clk);
    check("sel_ov", 64'(ov4), 64'd1);
    check("sel_od", 64'(od4), 64'h33);
    check("sel_os", 64'(os4), 64'd2);
    check("sel_ir2", 64'(ir4), 64'd1);
    step(); @(negedge clk); check("sel_drain", 64'(ov4), 64'd0);

    // out-of-range select on the 3-way instance
    step(); din3 = {8'h33, 8'h22, 8'h11}; sel3 = 2'd3; iv3 = 1'b1; ordy3 = 1'b1;
    step(); sel3 = 2'd1;
    @(negedge clk); check("oor_od", 64'(od3), 64'h11); check("oor_os", 64'(os3), 64'd0);
    step(); iv3 = 1'b0;
    @(negedge clk); check("in_od", 64'(od3), 64'h22); check("in_os", 64'(os3), 64'd1);

    // back-pressure into the skid entry
    step(); sel4 = 2'd0; din4[31:0] = 32'hA0; iv4 = 1'b1; ordy4 = 1'b0;
    step(); din4[31:0] = 32'hA1;
    @(negedge clk); check("bp_ir_one", 64'(ir4), 64'd1); check("bp_od_a0", 64'(od4), 64'hA0);
    step(); din4[31:0] = 32'hA2;
    @(negedge clk); check("bp_ir_full", 64'(ir4), 64'd0); check("bp_ov", 64'(ov4), 64'd1);
    step();
    @(negedge clk); check("bp_hold", 64'(od4), 64'hA0); check("bp_ir_hold", 64'(ir4), 64'd0);
    step(); ordy4 = 1'b1;
    @(negedge clk); check("bp_ir_rel", 64'(ir4), 64'd0);
    step();
    @(negedge clk); check("bp_od_a1", 64'(od4), 64'hA1); check("bp_ir_back", 64'(ir4), 64'd1);
    step(); iv4 = 1'b0;
    @(negedge clk); check("bp_od_a2", 64'(od4), 64'hA2);
    step();
    @(negedge clk); check("bp_empty", 64'(ov4), 64'd0); check("bp_q", 64'(q4.size()), 64'd0);

    // flush while FULL, with a pending input
    step(); din4[31:0] = 32'hC0; iv4 = 1'b1; ordy4 = 1'b0;
    step(); din4[31:0] = 32'hC1;
    step(); din4[31:0] = 32'hBB; fl4 = 1'b1;
    @(negedge clk); check("fl_full_ir", 64'(ir4), 64'd0); check("fl_full_ov", 64'(ov4), 64'd1);
    step(); fl4 = 1'b0; iv4 = 1'b0; ordy4 = 1'b1; q4.delete();
    @(negedge clk); check("fl_ov", 64'(ov4), 64'd0); check("fl_ir", 64'(ir4), 64'd1);
    // flush in EMPTY drops the same-cycle accept
    step(); din4[31:0] = 32'hBD; iv4 = 1'b1; fl4 = 1'b1;
    step(); fl4 = 1'b0; iv4 = 1'b0;
    @(negedge clk); check("fl_drop", 64'(ov4), 64'd0);
    step(); @(negedge clk); check("fl_quiet", 64'(ov4), 64'd0);

    // no-skid pass-through with toggling out_ready
    step(); sel0 = 2'd1; din0[63:32] = 32'hD0; iv0 = 1'b1; ordy0 = 1'b1;
    @(negedge clk); check("ns_ir0", 64'(ir0), 64'd1);
    step(); din0[63:32] = 32'hD1;
    @(negedge clk); check("ns_ir1", 64'(ir0), 64'd1); check("ns_od0", 64'(od0), 64'hD0);
    step(); din0[63:32] = 32'hD2; ordy0 = 1'b0;
    @(negedge clk); check("ns_ir_stall", 64'(ir0), 64'd0); check("ns_od1", 64'(od0), 64'hD1);
    #1 ordy0 = 1'b1;
    #1 check("ns_ir_comb", 64'(ir0), 64'd1);
    ordy0 = 1'b0;
    #1 check("ns_ir_comb0", 64'(ir0), 64'd0);
    step(); ordy0 = 1'b1;
    @(negedge clk); check("ns_ir2", 64'(ir0), 64'd1); check("ns_hold", 64'(od0), 64'hD1);
    step(); iv0 = 1'b0;
    @(negedge clk); check("ns_od2", 64'(od0), 64'hD2);
    step(); @(negedge clk); check("ns_empty", 64'(ov0), 64'd0);

    // async reset while FULL
    step(); sel4 = 2'd0; din4[31:0] = 32'hE0; iv4 = 1'b1; ordy4 = 1'b0;
    step(); din4[31:0] = 32'hE1;
    step(); iv4 = 1'b0;
    @(negedge clk); check("ar_full_ir", 64'(ir4), 64'd0); check("ar_full_ov", 64'(ov4), 64'd1);
    #2 reset_n = 1'b0;
    #1 check("ar_ov", 64'(ov4), 64'd0); check("ar_od", 64'(od4), 64'd0); check("ar_ir", 64'(ir4), 64'd1);
    q4.delete();
    #1 reset_n = 1'b1;
    step(); din4[31:0] = 32'hF0; iv4 = 1'b1; ordy4 = 1'b1;
    @(negedge clk); check("ar_ir_post", 64'(ir4), 64'd1); check("ar_ov_post", 64'(ov4), 64'd0);
    step(); iv4 = 1'b0;
    @(negedge clk); check("ar_od_f0", 64'(od4), 64'hF0); check("ar_ov_f0", 64'(ov4), 64'd1);
    step(); @(negedge clk); check("ar_drain", 64'(ov4), 64'd0);

    check("end_q4", 64'(q4.size()), 64'd0);
    check("end_q3", 64'(q3.size()), 64'd0);
    check("end_q0", 64'(q0.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_sel_stage.md
Name: pipe_sel_stage

Overview:
- Parametrised N:1 source select feeding a registered pipeline stage with valid/ready handshake, optional 2-entry skid buffer and synchronous flush.
- Successor to the plain combinational 2:1/3:1 selectors. Used between pipeline stages where forwarded operands are chosen and registered in one place.
- Carries stall (back-pressure) and flush (bubble insertion) for hazard handling.

Parameters:
- WIDTH, 32, data width per source.
- NUM_IN, 4, number of selectable sources; legal range 2..16.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
- SEL_W, derived localparam = ceil(log2(NUM_IN)); select width.

Ports:
- clk  input  1  clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_data  input  NUM_IN*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  source index.
- in_valid  input  1  upstream has data.
- in_ready  output  1  stage can accept.
- flush  input  1  synchronous kill of all held entries.
- out_data  output  WIDTH  registered selected data.
- out_sel  output  SEL_W  effective index that produced out_data (after range clamp).
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts.

Behaviour:
- Select: effective index = in_sel if in_sel < NUM_IN, else 0. Same default-to-source-0 rule as existing selectors.
- Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
- Latency: accepted data appears on out_data/out_valid the next cycle. Throughput 1 per cycle when out_ready stays high.
- Reset (reset_n low, async): out_valid=0, out_data=0, out_sel=0, skid entry invalid and zeroed. in_ready=1 while in reset and after release.
- SKID=1 state machine over {main_v, skid_v}:
  - EMPTY(0,0): accept -> ONE.
  - ONE(1,0):
    - accept && transfer -> ONE, main reloaded.
    - accept && !transfer -> FULL, new data goes to skid.
    - transfer only -> EMPTY.
    - neither -> hold.
  - FULL(1,1): in_ready=0, so no accept. Transfer -> ONE, skid moves to main. Otherwise hold.
  - in_ready = !skid_v, taken from a register. No combinational path from out_ready to in_ready.
- SKID=0: one entry. in_ready = !out_valid || out_ready (combinational). Accept loads main; transfer without accept clears out_valid.
- out_data/out_sel are stable while out_valid && !out_ready (stall hold; no glitch, no overwrite).
- Flush:
  - Flush high at an edge clears main_v and skid_v; next cycle out_valid=0 and in_ready=1.
  - Any accept in the flush cycle is dropped.
  - A transfer in the flush cycle still counts downstream; flush has no effect on data already consumed.
  - out_data keeps its last value after flush (don't-care when invalid).
- Flush and reset together: reset dominates.
- Reset asserted mid-transfer: all entries lost and outputs go to reset values immediately (async).

Decomposition:
- Shared package pipe_pkg: clog2 function, SEL_W derivation, state encoding constants ST_EMPTY/ST_ONE/ST_FULL.
- Sub-module pipe_mux_n: combinational N:1 selector with WIDTH/NUM_IN parameters. Includes the range clamp and outputs the effective index. Instantiated once.
- The handshake/skid logic stays in pipe_sel_stage.

Test Plan:
- Reset/basic select: reset_n low 3 cycles, release. NUM_IN=4, sources 0x11,0x22,0x33,0x44, in_sel=2, in_valid=1, out_ready=1 -> next cycle out_data=0x33, out_sel=2, out_valid=1. in_ready=1 throughout.
- Out-of-range select: NUM_IN=3, in_sel=3 -> out_data = source 0, out_sel=0.
- Back-pressure (SKID=1): stream 0xA0,0xA1,0xA2 with out_ready=0 from cycle 1 -> out_data holds 0xA0, 0xA1 held in skid, in_ready=0. 0xA2 is not accepted until out_ready=1. Output order is then 0xA0,0xA1,0xA2, one per cycle, with no loss or duplication.
- Flush while FULL: two entries held, flush=1 with in_valid=1 (0xBB) -> next cycle out_valid=0, in_ready=1, 0xBB never appears.
- SKID=0 pass-through: out_ready toggled 1,0,1 with continuous in_valid -> in_ready follows out_ready combinationally while out_valid=1. Data order is preserved with 1-cycle latency.
- Async reset mid-stream: reset_n pulsed low between edges while FULL -> out_valid=0 immediately. After release, in_ready=1 and the state is EMPTY.
